// File: rtl/state_uart_pkg.sv
// Shared constants, state encodings and frame byte selection for the state UART reporter.
// Optional even-parity bit per byte is enabled with STATE_UART_PARITY_EN.
package state_uart_pkg;

  localparam logic [7:0] HDR_S     = 8'h53;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] EOL       = 8'h0A;
  localparam logic [1:0] LAST_BYTE = 2'd2;

  typedef enum logic [1:0] {
    F_IDLE,
    F_LOAD,
    F_SEND
  } frame_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } ser_state_e;

  // Byte idx of the report frame: 'S', ASCII digit of the snapshot, newline.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [2:0] snap);
    case (idx)
      2'd0:    frame_byte = HDR_S;
      2'd1:    frame_byte = ASCII_0 + {5'b0, snap};
      default: frame_byte = EOL;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART serializer, LSB first, each bit held DIV clocks.
// STATE_UART_PARITY_EN inserts an even-parity bit between d7 and the stop bit.
module uart_byte_tx
  import state_uart_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       line,
  output logic       done,
  output logic       near_done_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  ser_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          line_q, line_d;
  logic          done_q;
`ifdef STATE_UART_PARITY_EN
  logic          par_q, par_d;
`endif

  logic bit_end_c;
  logic accept_c;

  assign bit_end_c   = (cnt_q == CW'(DIV - 1));
  // One cycle ahead of done so the registered pulse lands on the last stop cycle.
  assign near_done_c = (state_q == S_STOP) && (cnt_q == CW'(DIV - 2));
  // A new byte may follow the stop bit with no idle gap.
  assign accept_c    = start && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end_c));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    line_d  = line_q;
`ifdef STATE_UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        line_d = 1'b1;
      end
      S_START: begin
        if (bit_end_c) begin
          cnt_d   = '0;
          state_d = S_DATA;
          bit_d   = 3'd0;
          line_d  = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef STATE_UART_PARITY_EN
            state_d = S_PARITY;
            line_d  = par_q;
`else
            state_d = S_STOP;
            line_d  = 1'b1;
`endif
          end else begin
            bit_d  = bit_q + 3'd1;
            line_d = sh_q[0];
            sh_d   = {1'b0, sh_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
`ifdef STATE_UART_PARITY_EN
        if (bit_end_c) begin
          cnt_d   = '0;
          state_d = S_STOP;
          line_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        cnt_d   = '0;
        state_d = S_IDLE;
        line_d  = 1'b1;
`endif
      end
      S_STOP: begin
        if (bit_end_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          line_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        line_d  = 1'b1;
      end
    endcase
    if (accept_c) begin
      state_d = S_START;
      cnt_d   = '0;
      line_d  = 1'b0;
      sh_d    = data;
`ifdef STATE_UART_PARITY_EN
      par_d   = ^data;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      line_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef STATE_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      line_q  <= line_d;
      done_q  <= near_done_c;
`ifdef STATE_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign line = line_q;
  assign done = done_q;

endmodule

// File: rtl/state_uart_tx.sv
// Reports every change of the 3-bit detected state as "S<digit>\n" over UART.
// Define STATE_UART_PARITY_EN for an even-parity bit in every byte.
module state_uart_tx
  import state_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state,
  input  logic       send_req,
  output logic       txd,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned DIV = CLK_HZ / BAUD;

  frame_state_e fsm_q, fsm_d;
  logic [1:0]   idx_q, idx_d;
  logic [2:0]   snap_q, snap_d;
  logic [2:0]   reported_q, reported_d;
  logic         pending_q, pending_d;
  logic         force_q, force_d;
  logic         busy_q, busy_d;
  logic         frame_done_q, frame_done_d;

  logic         ser_start_c;
  logic [7:0]   ser_data_c;
  logic         ser_line;
  logic         ser_done;
  logic         ser_near_done_c;

  uart_byte_tx #(
    .DIV(DIV)
  ) u_byte_tx (
    .clk        (clk),
    .reset      (reset),
    .start      (ser_start_c),
    .data       (ser_data_c),
    .line       (ser_line),
    .done       (ser_done),
    .near_done_c(ser_near_done_c)
  );

  // force_q keeps a report request alive so a state that wanders back cannot cancel it.
  always_comb begin
    fsm_d        = fsm_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    reported_d   = reported_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    force_d      = force_q | send_req;
    pending_d    = (state != reported_q) | send_req | force_q;
    ser_start_c  = 1'b0;
    ser_data_c   = HDR_S;
    case (fsm_q)
      F_IDLE: begin
        if (pending_q) begin
          ser_start_c = 1'b1;
          busy_d      = 1'b1;
          fsm_d       = F_LOAD;
        end
      end
      F_LOAD: begin
        snap_d     = state;
        reported_d = state;
        pending_d  = send_req;
        force_d    = send_req;
        idx_d      = 2'd0;
        fsm_d      = F_SEND;
      end
      F_SEND: begin
        frame_done_d = (idx_q == LAST_BYTE) && ser_near_done_c;
        if (ser_done) begin
          if (idx_q == LAST_BYTE) begin
            busy_d = 1'b0;
            fsm_d  = F_IDLE;
          end else begin
            idx_d       = idx_q + 2'd1;
            ser_start_c = 1'b1;
            ser_data_c  = frame_byte(idx_q + 2'd1, snap_q);
          end
        end
      end
      default: fsm_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q        <= F_IDLE;
      idx_q        <= 2'd0;
      snap_q       <= 3'd0;
      reported_q   <= 3'd0;
      pending_q    <= 1'b0;
      force_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      reported_q   <= reported_d;
      pending_q    <= pending_d;
      force_q      <= force_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign txd        = ser_line;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_state_uart_tx.sv
// Directed bench for state_uart_tx: a UART decoder pops expected bytes from a scoreboard.
// Works for both builds; STATE_UART_PARITY_EN selects 11-bit bytes.
module tb_state_uart_tx;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
`ifdef STATE_UART_PARITY_EN
  localparam int unsigned BITS   = 11;
`else
  localparam int unsigned BITS   = 10;
`endif
  localparam int unsigned FRAME  = 3 * BITS * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state;
  logic       send_req;
  logic       txd;
  logic       busy;
  logic       frame_done;

  int         checks   = 0;
  int         errors   = 0;
  int         fd_total = 0;
  logic [7:0] sb[$];

  state_uart_tx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .send_req  (send_req),
    .txd       (txd),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_total = fd_total + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [2:0] s);
    logic [7:0] digit;
    digit = 8'h30 + {5'b0, s};
    sb.push_back(8'h53);
    sb.push_back(digit);
    sb.push_back(8'h0A);
  endtask

  task automatic settle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req();
    @(negedge clk) send_req = 1'b1;
    @(negedge clk) send_req = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int target);
    for (int unsigned i = 0; i < 4 * FRAME && fd_total < target; i++) @(negedge clk);
    check(tag, 32'(fd_total), 32'(target));
  endtask

  // Line decoder: samples mid-bit, drops bytes cut short by reset.
  initial begin : monitor
    logic [BITS-1:0] fr;
    logic            aborted;
    logic [7:0]      d;
    logic [7:0]      e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && txd === 1'b0) begin
        aborted = 1'b0;
        fr      = '0;
        for (int unsigned c = 1; c <= (BITS - 1) * DIV + DIV / 2; c++) begin
          @(negedge clk);
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (c % DIV == DIV / 2) fr[c / DIV] = txd;
        end
        if (!aborted) begin
          d = fr[8:1];
          check("start_bit", 32'(fr[0]), 32'(0));
          check("stop_bit", 32'(fr[BITS-1]), 32'(1));
`ifdef STATE_UART_PARITY_EN
          check("parity_bit", 32'(fr[9]), 32'(^d));
`endif
          check("sb_has_entry", 32'(sb.size() != 0), 32'(1));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rx_byte", 32'(d), 32'(e));
          end
        end
      end
    end
  end

  initial begin : stim
    int   bc;
    int   fc;
    int   fp;
    logic act;

    if (DIV < 4) $fatal(1, "DIV=%0d is below the minimum of 4", DIV);

    reset    = 1'b0;
    state    = 3'd0;
    send_req = 1'b0;
    settle(5);
    check("rst_txd", 32'(txd), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_fdone", 32'(frame_done), 32'(0));
    reset = 1'b1;
    act   = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) act = 1'b1;
    end
    check("quiet_after_reset", 32'(act), 32'(0));
    check("no_frame_after_reset", 32'(fd_total), 32'(0));

    // State change 0->3: latency, busy length and frame_done position.
    push_frame(3'd3);
    @(negedge clk) state = 3'd3;
    @(posedge clk); #1;
    check("lat_edge1_txd", 32'(txd), 32'(1));
    @(posedge clk); #1;
    check("lat_edge2_txd", 32'(txd), 32'(0));
    check("launch_busy", 32'(busy), 32'(1));
    bc = 0;
    fc = 0;
    fp = 0;
    for (int k = 1; k <= int'(FRAME) + 20; k++) begin
      if (busy === 1'b1) bc++;
      if (frame_done === 1'b1) begin
        fc++;
        fp = k;
      end
      @(posedge clk); #1;
    end
    check("busy_cycles", 32'(bc), 32'(FRAME));
    check("fdone_count", 32'(fc), 32'(1));
    check("fdone_pos", 32'(fp), 32'(FRAME));
    check("frame1_total", 32'(fd_total), 32'(1));
    check("sb_drained_1", 32'(sb.size()), 32'(0));

    // Coalescing: 5 then 6 during a forced frame for 3 yields a single frame for 6.
    push_frame(3'd3);
    push_frame(3'd6);
    pulse_req();
    settle(50);
    state = 3'd5;
    settle(100);
    state = 3'd6;
    wait_frames("coalesce_frames", 3);
    settle(2 * FRAME);
    check("coalesce_no_extra", 32'(fd_total), 32'(3));

    // Cancel: 3->5->3 inside one frame leaves nothing pending.
    push_frame(3'd3);
    @(negedge clk) state = 3'd3;
    settle(60);
    state = 3'd5;
    settle(60);
    state = 3'd3;
    wait_frames("cancel_frame", 4);
    settle(2 * FRAME);
    check("cancel_no_extra", 32'(fd_total), 32'(4));

    // Forced report with unchanged state.
    push_frame(3'd2);
    @(negedge clk) state = 3'd2;
    wait_frames("state2_frame", 5);
    settle(20);
    push_frame(3'd2);
    @(negedge clk) send_req = 1'b1;
    @(posedge clk); #1;
    check("req_lat_edge1_txd", 32'(txd), 32'(1));
    @(negedge clk) send_req = 1'b0;
    @(posedge clk); #1;
    check("req_lat_edge2_txd", 32'(txd), 32'(0));
    wait_frames("forced_frame", 6);
    settle(2 * FRAME);
    check("forced_no_extra", 32'(fd_total), 32'(6));

    // Two requests while busy collapse into one extra frame.
    push_frame(3'd2);
    push_frame(3'd2);
    pulse_req();
    settle(30);
    pulse_req();
    settle(100);
    pulse_req();
    wait_frames("double_req_frames", 8);
    settle(2 * FRAME);
    check("double_req_no_extra", 32'(fd_total), 32'(8));

    // Reset during byte 1, bit 4 (d3 of 0x37 is 0).
    sb.push_back(8'h53);
    @(negedge clk) state = 3'd7;
    act = 1'b0;
    for (int unsigned i = 0; i < 10 && !act; i++) begin
      @(negedge clk);
      if (txd === 1'b0) act = 1'b1;
    end
    check("midrst_launch", 32'(act), 32'(1));
    settle(BITS * DIV + 4 * DIV + 2);
    check("midrst_pre_txd", 32'(txd), 32'(0));
    push_frame(3'd4);
    state = 3'd4;
    reset = 1'b0;
    #1;
    check("midrst_txd", 32'(txd), 32'(1));
    check("midrst_busy", 32'(busy), 32'(0));
    settle(5);
    reset = 1'b1;
    wait_frames("post_reset_frame", 9);
    settle(FRAME);
    check("post_reset_no_extra", 32'(fd_total), 32'(9));
    check("sb_empty_end", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
